// File: rtl/data_mem_arbiter_if.sv
// Bus bundle for the data memory arbiter: two requester ports with a
// valid/ready request handshake and done/rdata completion, plus the
// single-port memory drive and a debug view of the arbiter FSM state.
//
// Handshake: a request transfers on a rising edge where reqN_valid and
// reqN_ready are both high. The requester holds valid and all request fields
// stable until it sees ready; dropping valid before ready withdraws the
// request. ready is never high outside the arbiter's idle state, and reqN_done
// pulses for one cycle when the accepted request has finished.
interface data_mem_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    localparam int BW = DW / 8;

    // Port 0: core load/store unit
    logic          req0_valid;
    logic          req0_ready;
    logic          req0_we;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic [BW-1:0] req0_be;
    logic          req0_done;
    logic [DW-1:0] req0_rdata;

    // Port 1: debug/DMA loader
    logic          req1_valid;
    logic          req1_ready;
    logic          req1_we;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic [BW-1:0] req1_be;
    logic          req1_done;
    logic [DW-1:0] req1_rdata;

    // Single-port memory, read data combinational from mem_A
    logic [AW-1:0] mem_A;
    logic          mem_WE;
    logic [DW-1:0] mem_WD;
    logic [DW-1:0] mem_RD;

    // Arbiter FSM state: 0 idle, 1 access, 2 write, 3 done
    logic [1:0]    dbg_state;

    // Environment side: requesters and the memory array
    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata, req0_be,
        input  req0_ready, req0_done, req0_rdata,
        output req1_valid, req1_we, req1_addr, req1_wdata, req1_be,
        input  req1_ready, req1_done, req1_rdata,
        input  mem_A, mem_WE, mem_WD,
        output mem_RD,
        input  dbg_state
    );

    // Arbiter side
    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata, req0_be,
        output req0_ready, req0_done, req0_rdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata, req1_be,
        output req1_ready, req1_done, req1_rdata,
        output mem_A, mem_WE, mem_WD,
        input  mem_RD,
        output dbg_state
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core
// load/store unit (port 0) and the debug/DMA loader (port 1). Byte-enabled
// stores that cover only part of a word become read-modify-write sequences,
// since the memory can only write whole words.
//
// Timing from the acceptance edge t: memory access in t+1, done in t+2;
// partial stores read in t+1, write in t+2 and complete in t+3.
module data_mem_arbiter #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    data_mem_arbiter_if.slave bus
);
    localparam int BW = DW / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state;
    logic          last_grant;

    // Transaction latched on the accepting edge
    logic          lat_port;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [BW-1:0] lat_be;

    // Registered outputs
    logic [DW-1:0] rdata_q;
    logic          done0_q;
    logic          done1_q;
    logic [AW-1:0] mem_a_q;
    logic          mem_we_q;
    logic [DW-1:0] mem_wd_q;

    // Grant decision and the granted port's request fields
    logic          gnt_valid;
    logic          gnt_port;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic [BW-1:0] sel_be;

    // Read-modify-write merge of store data into the word read back
    logic [DW-1:0] merged;
    logic          lat_be_full;
    logic          lat_be_none;

    // Pick a port in IDLE: a lone requester wins, a tie goes to the port
    // that did not win last time.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_port  = 1'b0;
        if (state == IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt_valid = 1'b1;
                gnt_port  = ~last_grant;
            end else if (bus.req0_valid) begin
                gnt_valid = 1'b1;
                gnt_port  = 1'b0;
            end else if (bus.req1_valid) begin
                gnt_valid = 1'b1;
                gnt_port  = 1'b1;
            end
        end
    end

    // Route the granted port's request fields toward the latch.
    always_comb begin
        sel_we    = bus.req0_we;
        sel_addr  = bus.req0_addr;
        sel_wdata = bus.req0_wdata;
        sel_be    = bus.req0_be;
        if (gnt_port) begin
            sel_we    = bus.req1_we;
            sel_addr  = bus.req1_addr;
            sel_wdata = bus.req1_wdata;
            sel_be    = bus.req1_be;
        end
    end

    // Per byte, take store data where enabled and the current word elsewhere.
    always_comb begin
        merged = '0;
        for (int i = 0; i < BW; i++) begin
            merged[8*i +: 8] = lat_be[i] ? lat_wdata[8*i +: 8] : bus.mem_RD[8*i +: 8];
        end
    end

    assign lat_be_full = &lat_be;
    assign lat_be_none = ~|lat_be;

    // Arbiter FSM: accept, access memory (optionally merge and write), complete.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lat_port   <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_be     <= '0;
            rdata_q    <= '0;
            done0_q    <= 1'b0;
            done1_q    <= 1'b0;
            mem_a_q    <= '0;
            mem_we_q   <= 1'b0;
            mem_wd_q   <= '0;
        end else begin
            // Memory drive and done are zero unless the next state asks otherwise
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            mem_a_q  <= '0;
            mem_we_q <= 1'b0;
            mem_wd_q <= '0;
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        lat_port   <= gnt_port;
                        lat_we     <= sel_we;
                        lat_addr   <= sel_addr;
                        lat_wdata  <= sel_wdata;
                        lat_be     <= sel_be;
                        last_grant <= gnt_port;
                        state      <= ACCESS;
                        // ACCESS presents the address; a full-word store
                        // writes directly in that same cycle.
                        mem_a_q    <= sel_addr;
                        if (sel_we && (&sel_be)) begin
                            mem_we_q <= 1'b1;
                            mem_wd_q <= sel_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (!lat_we) begin
                        rdata_q <= bus.mem_RD;
                        done0_q <= ~lat_port;
                        done1_q <= lat_port;
                        state   <= DONE;
                    end else if (lat_be_full || lat_be_none) begin
                        done0_q <= ~lat_port;
                        done1_q <= lat_port;
                        state   <= DONE;
                    end else begin
                        // Partial store: the merged word is written in WRITE
                        mem_a_q  <= lat_addr;
                        mem_we_q <= 1'b1;
                        mem_wd_q <= merged;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    done0_q <= ~lat_port;
                    done1_q <= lat_port;
                    state   <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready = gnt_valid && !gnt_port;
    assign bus.req1_ready = gnt_valid && gnt_port;
    assign bus.req0_done  = done0_q;
    assign bus.req1_done  = done1_q;
    assign bus.req0_rdata = rdata_q;
    assign bus.req1_rdata = rdata_q;
    assign bus.mem_A      = mem_a_q;
    assign bus.mem_WE     = mem_we_q;
    assign bus.mem_WD     = mem_wd_q;
    assign bus.dbg_state  = state;

    // Completion is exclusive to one port.
    a_done_onehot: assert property (@(posedge clk) disable iff (rst)
        !(bus.req0_done && bus.req1_done));

    // Writes only happen in the access or write phases.
    a_we_phase: assert property (@(posedge clk) disable iff (rst)
        bus.mem_WE |-> (state == ACCESS || state == WRITE));

    // Grants are only offered in IDLE.
    a_ready_idle: assert property (@(posedge clk) disable iff (rst)
        (bus.req0_ready || bus.req1_ready) |-> (state == IDLE));
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: memory array model, directed scenarios with
// literal expectations, and randomized two-port traffic checked every cycle
// against a transaction-level reference model.
module tb_data_mem_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic [AW-1:0] a;
        logic          we;
        logic [DW-1:0] wd;
        logic          d0;
        logic          d1;
        logic          rv;
    } slot_t;

    typedef struct packed {
        int port;
        int cyc;
    } grant_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    data_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    data_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- memory array ----------------
    logic [DW-1:0] mem [0:DEPTH-1];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    assign bus.mem_RD = (bus.mem_A == '0) ? '0 : mem[bus.mem_A];

    always @(posedge clk) begin
        if (bus.mem_WE === 1'b1) mem[bus.mem_A] <= bus.mem_WD;
        else if (pl_en) mem[pl_addr] <= pl_data;
    end

    // ---------------- check helper ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    slot_t         sched [int];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_rdata = '0;
    int            free_at = 0;
    int            last = 1;
    bit            armed = 1'b0;

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return (a == '0) ? '0 : ref_mem[a];
    endfunction

    function automatic logic [DW-1:0] be_mask(input logic [BW-1:0] be);
        logic [DW-1:0] m;
        m = '0;
        for (int i = 0; i < BW; i++) if (be[i]) m = m | ({{(DW-8){1'b0}}, 8'hFF} << (8 * i));
        return m;
    endfunction

    task automatic sched_mem(input int c, input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd);
        slot_t s;
        s = '0;
        if (sched.exists(c)) s = sched[c];
        s.a = a; s.we = we; s.wd = wd;
        sched[c] = s;
    endtask

    task automatic sched_done(input int c, input int p, input logic ld);
        slot_t s;
        s = '0;
        if (sched.exists(c)) s = sched[c];
        s.d0 = (p == 0); s.d1 = (p == 1); s.rv = ld;
        sched[c] = s;
    endtask

    // Per-cycle compare against the model's expected outputs.
    always @(negedge clk) begin
        slot_t         e;
        logic          v0, v1, gv, we;
        int            gp;
        logic [AW-1:0] a;
        logic [DW-1:0] wd, rd, mg, mk;
        logic [BW-1:0] be;
        if (pl_en) ref_mem[pl_addr] = pl_data;
        e = '0;
        if (sched.exists(cyc)) e = sched[cyc];
        if (e.rv) begin
            if (exp_q.size() > 0) exp_rdata = exp_q.pop_front();
            else chk("exp_q_underflow", 64'd1, 64'd0);
        end
        if (armed) begin
            chk("mem_A", bus.mem_A, e.a);
            chk("mem_WE", bus.mem_WE, e.we);
            chk("mem_WD", bus.mem_WD, e.wd);
            chk("req0_done", bus.req0_done, e.d0);
            chk("req1_done", bus.req1_done, e.d1);
            chk("req0_rdata", bus.req0_rdata, exp_rdata);
            chk("req1_rdata", bus.req1_rdata, exp_rdata);
        end
        sched.delete(cyc);
        if (rst) begin
            sched.delete();
            exp_q.delete();
            exp_rdata = '0;
            free_at = cyc + 1;
            last = 1;
            armed = 1'b1;
        end else if (armed) begin
            v0 = (bus.req0_valid === 1'b1);
            v1 = (bus.req1_valid === 1'b1);
            gv = 1'b0;
            gp = 0;
            if (cyc >= free_at) begin
                if (v0 && v1) begin gv = 1'b1; gp = (last == 0) ? 1 : 0; end
                else if (v0) begin gv = 1'b1; gp = 0; end
                else if (v1) begin gv = 1'b1; gp = 1; end
            end
            chk("req0_ready", bus.req0_ready, gv && gp == 0);
            chk("req1_ready", bus.req1_ready, gv && gp == 1);
            if (gv) begin
                we = (gp == 0) ? bus.req0_we    : bus.req1_we;
                a  = (gp == 0) ? bus.req0_addr  : bus.req1_addr;
                wd = (gp == 0) ? bus.req0_wdata : bus.req1_wdata;
                be = (gp == 0) ? bus.req0_be    : bus.req1_be;
                rd = ref_rd(a);
                last = gp;
                if (!we) begin
                    sched_mem(cyc + 1, a, 1'b0, '0);
                    sched_done(cyc + 2, gp, 1'b1);
                    exp_q.push_back(rd);
                    free_at = cyc + 3;
                end else if (be == '1) begin
                    sched_mem(cyc + 1, a, 1'b1, wd);
                    sched_done(cyc + 2, gp, 1'b0);
                    ref_mem[a] = wd;
                    free_at = cyc + 3;
                end else if (be == '0) begin
                    sched_mem(cyc + 1, a, 1'b0, '0);
                    sched_done(cyc + 2, gp, 1'b0);
                    free_at = cyc + 3;
                end else begin
                    mk = be_mask(be);
                    mg = (wd & mk) | (rd & ~mk);
                    sched_mem(cyc + 1, a, 1'b0, '0);
                    sched_mem(cyc + 2, a, 1'b1, mg);
                    sched_done(cyc + 3, gp, 1'b0);
                    ref_mem[a] = mg;
                    free_at = cyc + 4;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk); #1;
        pl_en = 1'b1; pl_addr = a; pl_data = d;
    endtask

    // Sample on the negedge of cycle n (call before that negedge has passed).
    task automatic goto(input int n);
        @(negedge clk);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic set_port(input int p, input logic v, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic [BW-1:0] be);
        if (p == 0) begin
            bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = wd; bus.req0_be = be; bus.req0_valid = v;
        end else begin
            bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = wd; bus.req1_be = be; bus.req1_valid = v;
        end
    endtask

    // Raise a request and hold it until ready or until patience runs out.
    task automatic do_req(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input logic [BW-1:0] be, input int patience, output bit acc, output int t);
        logic rdy;
        acc = 1'b0;
        t = 0;
        @(posedge clk); #1;
        set_port(p, 1'b1, we, a, wd, be);
        for (int k = 0; k < patience; k++) begin
            @(negedge clk);
            rdy = (p == 0) ? bus.req0_ready : bus.req1_ready;
            if (rdy === 1'b1) begin
                acc = 1'b1;
                t = cyc;
                break;
            end
        end
        if (!acc && patience > 1) chk($sformatf("port%0d_grant_timeout", p), 64'd0, 64'd1);
        @(posedge clk); #1;
        set_port(p, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic rand_port(input int p, input int n);
        bit            acc;
        int            t, sel;
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [BW-1:0] be;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            sel = $urandom_range(0, 9);
            a = (sel == 0) ? '0 : (sel == 1) ? AW'(DEPTH - 1) : AW'($urandom_range(0, 31));
            we = $urandom_range(0, 1);
            wd = $urandom();
            sel = $urandom_range(0, 3);
            be = (sel == 0) ? '1 : (sel == 1) ? '0 : BW'($urandom_range(0, 15));
            do_req(p, we, a, wd, be, ($urandom_range(0, 7) == 0) ? 1 : 60, acc, t);
        end
    endtask

    // ---------------- stimulus ----------------
    grant_t gq [$];

    initial begin
        bit acc;
        int t;
        set_port(0, 1'b0, 1'b0, '0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0, '0);

        for (int i = 0; i < DEPTH; i++) preload(AW'(i), $urandom());
        preload(10'd5, 32'hDEADBEEF);
        preload(10'd3, 32'hAABBCCDD);
        preload(10'd7, 32'h07070707);
        preload(10'd0, 32'h55AA55AA);
        preload(10'd9, 32'h00000000);
        @(posedge clk); #1;
        pl_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_mem_A", bus.mem_A, 0);
        chk("rst_mem_WE", bus.mem_WE, 0);
        chk("rst_mem_WD", bus.mem_WD, 0);
        chk("rst_done", {bus.req0_done, bus.req1_done}, 0);
        chk("rst_rdata", bus.req0_rdata, 0);
        chk("rst_state", bus.dbg_state, 0);

        // Contention: both ports load continuously, grants alternate from port 0
        fork
            for (int k = 0; k < 4; k++) begin
                bit a0; int t0;
                do_req(0, 1'b0, AW'(20 + k), '0, '0, 60, a0, t0);
                gq.push_back('{port: 0, cyc: t0});
            end
            for (int k = 0; k < 4; k++) begin
                bit a1; int t1;
                do_req(1, 1'b0, AW'(40 + k), '0, '0, 60, a1, t1);
                gq.push_back('{port: 1, cyc: t1});
            end
        join
        chk("contention_count", gq.size(), 8);
        for (int i = 0; i < gq.size(); i++) begin
            chk($sformatf("contention_port%0d", i), gq[i].port, i % 2);
            if (i > 0) chk($sformatf("contention_gap%0d", i), gq[i].cyc - gq[i-1].cyc, 3);
        end

        // Single load, port 0
        do_req(0, 1'b0, 10'd5, '0, '0, 60, acc, t);
        goto(t + 1);
        chk("load_mem_A", bus.mem_A, 5);
        chk("load_mem_WE", bus.mem_WE, 0);
        goto(t + 2);
        chk("load_done0", bus.req0_done, 1);
        chk("load_rdata", bus.req0_rdata, 32'hDEADBEEF);
        chk("load_done1", bus.req1_done, 0);

        // Full store, port 1, then read back
        do_req(1, 1'b1, 10'd9, 32'h12345678, 4'hF, 60, acc, t);
        goto(t + 1);
        chk("full_we", bus.mem_WE, 1);
        chk("full_wd", bus.mem_WD, 32'h12345678);
        goto(t + 2);
        chk("full_we_off", bus.mem_WE, 0);
        chk("full_done1", bus.req1_done, 1);
        do_req(0, 1'b0, 10'd9, '0, '0, 60, acc, t);
        goto(t + 2);
        chk("full_readback", bus.req0_rdata, 32'h12345678);

        // Partial store, port 0
        do_req(0, 1'b1, 10'd3, 32'h11223344, 4'b0101, 60, acc, t);
        goto(t + 1);
        chk("part_read_we", bus.mem_WE, 0);
        goto(t + 2);
        chk("part_write_we", bus.mem_WE, 1);
        chk("part_write_wd", bus.mem_WD, 32'hAA22CC44);
        chk("part_no_early_done", bus.req0_done, 0);
        goto(t + 3);
        chk("part_done", bus.req0_done, 1);

        // Empty store leaves the word alone
        do_req(1, 1'b1, 10'd7, 32'hFFFFFFFF, 4'h0, 60, acc, t);
        goto(t + 1);
        chk("be0_we_t1", bus.mem_WE, 0);
        goto(t + 2);
        chk("be0_we_t2", bus.mem_WE, 0);
        chk("be0_done", bus.req1_done, 1);
        do_req(0, 1'b0, 10'd7, '0, '0, 60, acc, t);
        goto(t + 2);
        chk("be0_unchanged", bus.req0_rdata, 32'h07070707);

        // Address 0 reads as zero; top address is an ordinary word
        do_req(1, 1'b0, 10'd0, '0, '0, 60, acc, t);
        goto(t + 2);
        chk("addr0_rdata", bus.req1_rdata, 0);
        do_req(0, 1'b1, 10'h3FF, 32'hCAFEF00D, 4'hF, 60, acc, t);
        goto(t + 1);
        chk("top_mem_A", bus.mem_A, 10'h3FF);
        do_req(1, 1'b0, 10'h3FF, '0, '0, 60, acc, t);
        goto(t + 2);
        chk("top_readback", bus.req1_rdata, 32'hCAFEF00D);

        // Reset during the write phase of a partial store
        do_req(0, 1'b1, 10'd3, 32'h99887766, 4'b0011, 60, acc, t);
        goto(t + 1);
        @(posedge clk); #1;
        rst = 1'b1;
        goto(t + 2);
        chk("rstmid_we_in_write", bus.mem_WE, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        set_port(0, 1'b1, 1'b0, 10'd5, '0, '0);
        set_port(1, 1'b1, 1'b0, 10'd9, '0, '0);
        goto(t + 3);
        chk("rstmid_we_after", bus.mem_WE, 0);
        chk("rstmid_done", {bus.req0_done, bus.req1_done}, 0);
        chk("rstmid_mem_A", bus.mem_A, 0);
        chk("rstmid_rdata", bus.req0_rdata, 0);
        chk("rstmid_tie_ready0", bus.req0_ready, 1);
        chk("rstmid_tie_ready1", bus.req1_ready, 0);
        @(posedge clk); #1;
        set_port(0, 1'b0, 1'b0, '0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (4) @(posedge clk);

        // Randomized traffic on both ports
        fork
            rand_port(0, 150);
            rand_port(1, 150);
        join
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
